// File: rtl/lcd_frame_capture_if.sv
// Video-in plus frame-buffer write bundle for the frame capture block.
// The master drives the panel stream and START; the slave writes the RAM.
interface lcd_frame_capture_if #(
    parameter int AW = 17
);
    logic          PIX_EN;
    logic          HD;
    logic          VD;
    logic          DEN;
    logic [7:0]    R;
    logic [7:0]    G;
    logic [7:0]    B;
    logic          START;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [15:0]   WR_DATA;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    modport master (
        output PIX_EN, HD, VD, DEN, R, G, B, START,
        input  WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR
    );

    modport slave (
        input  PIX_EN, HD, VD, DEN, R, G, B, START,
        output WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR
    );
endinterface

// File: rtl/lcd_frame_capture.sv
// Captures one HD/VD/DEN RGB888 frame per START into a 16-bit RAM,
// packed to RGB565 and decimated 2x in both directions.
module lcd_frame_capture #(
    parameter int H_ACT = 800,
    parameter int V_ACT = 480,
    parameter int AW    = 17
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    lcd_frame_capture_if.slave   bus
);
    localparam int CW = $clog2(H_ACT + 1);
    localparam int RW = $clog2(V_ACT + 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'((H_ACT / 2) * (V_ACT / 2) - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, FINISH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          vd_q, den_q;
    logic          vd_fall, den_fall;
    logic          ign_unused;

    // HD carries no information here: lines are delimited by DEN alone.
    assign ign_unused = ^{bus.HD, bus.R[2:0], bus.G[1:0], bus.B[2:0]};

    assign vd_fall  = bus.PIX_EN & vd_q & ~bus.VD;
    assign den_fall = bus.PIX_EN & den_q & ~bus.DEN;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            vd_q      <= 1'b0;
            den_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (bus.PIX_EN) begin
                vd_q  <= bus.VD;
                den_q <= bus.DEN;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = WAIT_VS;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            WAIT_VS: begin
                if (vd_fall) begin
                    state_d = CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            CAPTURE: begin
                if (den_fall) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    // Last line completing beats a coincident VD fall.
                    if (row_q == RW'(V_ACT - 1)) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (vd_fall) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end else if (vd_fall) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (bus.PIX_EN && bus.DEN && col_q < CW'(H_ACT)) begin
                    col_d = col_q + 1'b1;
                    if (!col_q[0] && !row_q[0] && addr_q <= ADDR_MAX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {bus.R[7:3], bus.G[7:2], bus.B[7:3]};
                        addr_d    = addr_q + 1'b1;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.WR_EN   = wr_en_q;
    assign bus.WR_ADDR = wr_addr_q;
    assign bus.WR_DATA = wr_data_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Scoreboard bench for lcd_frame_capture on a shrunken 8x4 frame.
module tb_lcd_frame_capture;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 17;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    lcd_frame_capture_if #(.AW(AW)) vif ();

    lcd_frame_capture #(.H_ACT(H), .V_ACT(V), .AW(AW)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (vif)
    );

    always #5 CLK = ~CLK;

    exp_t          sb[$];
    logic [15:0]   obs[$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    logic [AW-1:0] exp_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pk(input logic [23:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (vif.WR_EN) begin
            wr_cnt++;
            obs.push_back(vif.WR_DATA);
            if (sb.size() == 0) begin
                chk("wr_unexp", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(vif.WR_ADDR), 32'(e.addr));
                chk("wr_data", 32'(vif.WR_DATA), 32'(e.data));
                chk("wr_lat", cyc, e.cyc);
            end
        end
        if (vif.DONE) begin
            done_cnt++;
            chk("done_err", 32'(vif.ERR), 0);
        end
    end

    // One PIX_EN sample followed by gap-1 idle cycles.
    task automatic samp(input logic hd, vd, den, input logic [23:0] rgb,
                        input bit push, input int gap);
        @(negedge CLK);
        vif.HD = hd; vif.VD = vd; vif.DEN = den;
        {vif.R, vif.G, vif.B} = rgb;
        vif.PIX_EN = 1'b1;
        if (push) begin
            sb.push_back('{exp_addr, pk(rgb), cyc + 1});
            exp_addr++;
        end
        repeat (gap - 1) begin
            @(negedge CLK);
            vif.PIX_EN = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        vif.PIX_EN = 1'b0;
        vif.START = 1'b1;
        @(negedge CLK);
        vif.START = 1'b0;
    endtask

    task automatic frame(input int nl, gap, len0, input bit act, ovr, sim_last,
                         err_vd, mid_start, output int nw);
        logic [23:0] c;
        nw = 0;
        exp_addr = '0;
        samp(1, 1, 0, 24'h0, 0, gap);
        samp(1, 1, 1, $urandom, 0, gap);
        samp(1, 1, 1, $urandom, 0, gap);
        samp(1, 1, 0, 24'h0, 0, gap);
        samp(1, 0, 0, 24'h0, 0, gap);
        samp(1, 1, 0, 24'h0, 0, gap);
        for (int l = 0; l < nl; l++) begin
            samp(0, 1, 0, 24'h0, 0, gap);
            samp(1, 1, 0, 24'h0, 0, gap);
            for (int x = 0; x < ((l == 0) ? len0 : H); x++) begin
                bit p;
                c = 24'($urandom);
                if (ovr && l == 0 && x == 0) c = 24'hFF00FF;
                if (ovr && l == 0 && x == 2) c = 24'h123456;
                p = act && x < H && (x % 2 == 0) && (l % 2 == 0);
                if (p) nw++;
                samp(1, 1, 1, c, p, gap);
            end
            samp(1, (sim_last && l == nl - 1) ? 1'b0 : 1'b1, 0, 24'h0, 0, gap);
            samp(1, 1, 0, 24'h0, 0, gap);
            if (mid_start && l == 1) pulse_start();
        end
        if (err_vd) samp(1, 0, 0, 24'h0, 0, gap);
        samp(1, 1, 0, 24'h0, 0, gap);
        samp(1, 1, 0, 24'h0, 0, gap);
        @(negedge CLK);
        vif.PIX_EN = 1'b0;
    endtask

    task automatic fin(input string t, input int exp_done, input bit exp_err,
                       input int d0, input int w0, input int exp_w);
        int k = 0;
        while (vif.BUSY && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk({t, "_busy"}, 32'(vif.BUSY), 0);
        repeat (3) @(negedge CLK);
        chk({t, "_done"}, done_cnt - d0, exp_done);
        chk({t, "_err"}, 32'(vif.ERR), 32'(exp_err));
        chk({t, "_nwr"}, wr_cnt - w0, exp_w);
        chk({t, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        int d0, w0, nw, o0;
        vif.PIX_EN = 0; vif.HD = 1; vif.VD = 1; vif.DEN = 0;
        vif.R = 0; vif.G = 0; vif.B = 0; vif.START = 0;
        repeat (3) @(negedge CLK);
        chk("rst_wr_en", 32'(vif.WR_EN), 0);
        chk("rst_wr_addr", 32'(vif.WR_ADDR), 0);
        chk("rst_busy", 32'(vif.BUSY), 0);
        chk("rst_done", 32'(vif.DONE), 0);
        chk("rst_err", 32'(vif.ERR), 0);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Clean frame, every-cycle strobe, colour packing corners.
        d0 = done_cnt; w0 = wr_cnt; o0 = obs.size();
        pulse_start();
        chk("a_busy_set", 32'(vif.BUSY), 1);
        frame(V, 1, H, 1, 1, 0, 0, 0, nw);
        fin("a", 1, 0, d0, w0, 8);
        chk("pack_ff00ff", 32'(obs[o0]), 32'h0000F81F);
        chk("pack_123456", 32'(obs[o0 + 1]), 32'h000011AA);

        // Strobe every 4th cycle.
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        frame(V, 4, H, 1, 0, 0, 0, 0, nw);
        fin("b", 1, 0, d0, w0, 8);

        // Short frame: VD falls after two lines.
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        frame(2, 1, H, 1, 0, 0, 1, 0, nw);
        fin("c", 0, 1, d0, w0, 4);

        // START clears ERR; a second START mid-frame is ignored.
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        chk("d_err_clr", 32'(vif.ERR), 0);
        frame(V, 1, H, 1, 0, 0, 0, 1, nw);
        fin("d", 1, 0, d0, w0, 8);

        // No START: nothing is captured.
        d0 = done_cnt; w0 = wr_cnt;
        frame(V, 1, H, 0, 0, 0, 0, 0, nw);
        fin("e", 0, 0, d0, w0, 0);

        // Overlong first line, last DEN fall coincident with VD fall.
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        frame(V, 2, H + 2, 1, 0, 1, 0, 0, nw);
        fin("f", 1, 0, d0, w0, nw);
        chk("f_nw", nw, 8);

        // Short first line: missing pixels are simply not written.
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        frame(V, 1, 5, 1, 0, 0, 0, 0, nw);
        fin("g", 1, 0, d0, w0, 7);

        // Asynchronous reset while a write is on the bus.
        pulse_start();
        exp_addr = '0;
        samp(1, 1, 0, 24'h0, 0, 1);
        samp(1, 0, 0, 24'h0, 0, 1);
        samp(1, 1, 0, 24'h0, 0, 1);
        samp(1, 1, 1, 24'hA5C3E7, 1, 1);
        @(posedge CLK);
        #1;
        chk("r_pre_wr", 32'(vif.WR_EN), 1);
        RST_n = 1'b0;
        #1;
        chk("r_wr_en", 32'(vif.WR_EN), 0);
        chk("r_busy", 32'(vif.BUSY), 0);
        chk("r_done", 32'(vif.DONE), 0);
        sb.delete();
        vif.PIX_EN = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        d0 = done_cnt; w0 = wr_cnt;
        frame(V, 1, H, 0, 0, 0, 0, 0, nw);
        fin("r_idle", 0, 0, d0, w0, 0);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        frame(V, 1, H, 1, 0, 0, 0, 0, nw);
        fin("r_post", 1, 0, d0, w0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
